mips_fetch: RTL and testbench
=============================

# mips_fetch

Instruction fetch unit. Holds the PC, issues word reads to instruction memory over a valid/ready request channel, and absorbs in-order responses into a small flushable queue. It presents instructions, their PCs, and pre-split opcode/funct fields to the control decoder. It sits between instruction memory and the decode/control stage, and accepts branch/jump redirects from the execute stage.

## Interface
- `DEPTH`, 2 — queue entries; also the cap on outstanding requests plus queued entries.
- `RESET_PC`, 32'h0000_0000 — PC loaded on reset; must be word aligned.

Clock and reset:
- `clk` input 1 — single clock. All state updates on its rising edge.
- `rst` input 1 — synchronous, active-high reset.

Instruction memory request channel:
- `imem_req_valid` output 1 — read request valid.
- `imem_req_addr` output 32 — word-aligned byte address.
- `imem_req_ready` input 1 — memory accepts the request this cycle.

Instruction memory response channel:
- `imem_rsp_valid` input 1 — read data valid. Responses return in order, at least 1 cycle after acceptance, and have no backpressure.
- `imem_rsp_data` input 32 — instruction word.

Decode-side output:
- `inst_valid` output 1 — queue head is valid.
- `inst_ready` input 1 — decode consumes the head.
- `inst_data` output 32 — instruction word.
- `inst_pc` output 32 — address of `inst_data`.
- `inst_opcode` output 6 — `inst_data[31:26]`.
- `inst_funct` output 6 — `inst_data[5:0]`.

Redirect and error:
- `redirect_valid` input 1 — branch/jump taken.
- `redirect_pc` input 32 — new fetch address.
- `fetch_err` output 1 — sticky misaligned-redirect error.

## Operation
- State machine `BOOT -> RUN`, plus `RUN -> ERR`. `ERR` is left only by `rst`.
  - `BOOT`: lasts one cycle, issues no requests.
  - `RUN`: normal fetching.
  - `ERR`: entered on a redirect with `redirect_pc[1:0] != 0`. In `ERR`, `fetch_err` = 1, no requests are issued, the queue is flushed, and responses are discarded.
- Request rule:
  - `imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + count - pop) < DEPTH`, where `pop = inst_valid && inst_ready`.
  - `imem_req_addr` = PC.
  - On `imem_req_valid && imem_req_ready`: PC += 4 (mod 2^32, wraps silently) and `outstanding` += 1.
  - `imem_req_valid` may deassert without acceptance; the memory must not require a stable request.
- Response rule:
  - If `drop_cnt > 0`, the response is discarded and `drop_cnt` -= 1.
  - Otherwise the response is written to the queue together with its PC, which is tracked in a PC FIFO or recomputed from a tail PC.
  - Every response decrements `outstanding`.
  - Because of the credit rule, the queue never overflows.
- Redirect (`redirect_valid`, aligned) in cycle t:
  - PC <= `redirect_pc`.
  - The queue is flushed, including any pop in cycle t; decode must treat its cycle-t consume as squashed.
  - A response arriving in cycle t is dropped.
  - `drop_cnt` <= `outstanding - imem_rsp_valid`.
  - No request is issued in cycle t.
- Simultaneous issue, response, and pop all update the counters in the same cycle.
- Reset mid-operation: all counters, the queue, and the state are cleared. Any late memory responses after reset are the memory's responsibility; memory is reset with the same `rst`.
- Reset values:
  - `imem_req_valid` = 0, `imem_req_addr` = `RESET_PC`.
  - `inst_valid` = 0; `inst_data`, `inst_pc`, `inst_opcode`, `inst_funct` = 0.
  - `fetch_err` = 0.

## Timing
- First `imem_req_valid` occurs in the 2nd cycle after `rst` deasserts.
- Response to `inst_valid` takes 1 cycle, because the queue is registered with no bypass.
- Sustained rate is 1 instruction/cycle with 1-cycle memory, `inst_ready` = 1, and `DEPTH` >= 2.
- Redirect in cycle t gives the first request at the new PC in cycle t+1.
- Outputs to decode are held stable while `inst_valid && !inst_ready`.

## Configuration
- `MIPS_FETCH_JMP_PREDECODE_EN`, defined:
  - When the head is accepted (`pop`) and `inst_opcode == 6'h02` (J), the fetch unit self-redirects in that cycle.
  - Target is `{inst_pc_plus4[31:28], inst_data[25:0], 2'b00}`.
  - The self-redirect has the same flush/drop semantics as an external redirect, except that the J instruction itself is delivered.
  - An external `redirect_valid` in the same cycle wins.
- Not defined: no instruction inspection; jumps are resolved only through `redirect_valid`.

## Structure
- Shared package `mips_pkg`:
  - opcode constants `OP_RTYPE` = 6'h00, `OP_J` = 6'h02, `OP_BEQ` = 6'h04, `OP_ADDI` = 6'h08, `OP_LW` = 6'h23, `OP_SW` = 6'h2B;
  - funct constants;
  - the fetch state enum `t_fetch_state`.
- Sub-module `mips_fetch_fifo`: parameterised `DEPTH`, carries {pc, data}, has a synchronous flush, and outputs count.

## Test plan
- Reset release, `imem_req_ready` = 1, 1-cycle memory, `inst_ready` = 1:
  - addresses 0, 4, 8 are issued back-to-back;
  - `inst_pc` follows 0, 4, 8 at 1/cycle, starting 3 cycles after reset release.
- `inst_ready` held 0 with `DEPTH` = 2:
  - exactly 2 requests are issued and then `imem_req_valid` stays 0;
  - `inst_data` stays stable.
- Redirect to 0x100 with 2 requests outstanding:
  - both old responses are dropped;
  - the next delivered `inst_pc` is 0x100;
  - no stale instruction appears.
- Redirect to 0x102:
  - `fetch_err` = 1 next cycle;
  - `imem_req_valid` stays 0 until `rst`;
  - `rst` then restores `RESET_PC` fetching.
- With `MIPS_FETCH_JMP_PREDECODE_EN`, word 0x0800_0040 at PC 0x0:
  - the J is delivered;
  - the next delivered `inst_pc` is 0x100.
  - Without the macro, the next `inst_pc` is 0x4.
- Redirect in the same cycle as a response and a pop:
  - the counters end consistent;
  - `drop_cnt` equals `outstanding - 1`;
  - the queue is empty the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants and the fetch state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {BOOT, RUN, ERR} t_fetch_state;

    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// mips_fetch_if: instruction memory request/response channels.
interface mips_fetch_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: registered {pc, data} queue with synchronous flush and occupancy count.
module mips_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rp, wp;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop) rp <= nxt(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push && !flush) mem[wp] <= wdata;

    assign rdata = mem[rp];

endmodule

// File: rtl/mips_fetch.sv
// mips_fetch: PC, credit-limited imem requests and flushable instruction queue.
// Optional MIPS_FETCH_JMP_PREDECODE_EN: self-redirect on a delivered J instruction.
module mips_fetch
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    mips_fetch_if.master      imem,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    output logic [5:0]        inst_opcode,
    output logic [5:0]        inst_funct,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_err
);
    localparam int CW = $clog2(DEPTH+1);

    t_fetch_state  state, state_n;
    logic [31:0]   pc, target;
    logic [CW-1:0] outstanding, drop_cnt, count;
    logic [63:0]   head;
    logic          pop, jmp, redir, flush, fire, drop, push;

    assign pop = inst_valid && inst_ready;
`ifdef MIPS_FETCH_JMP_PREDECODE_EN
    assign jmp    = pop && inst_opcode == OP_J;
    assign target = redirect_valid ? redirect_pc : jump_target(inst_pc + 32'd4, inst_data[25:0]);
`else
    assign jmp    = 1'b0;
    assign target = redirect_pc;
`endif
    assign redir = redirect_valid || jmp;
    assign flush = redir || state == ERR;
    assign drop  = drop_cnt != '0;
    assign push  = imem.rsp_valid && !drop && !flush;

    // credits cover both in-flight requests and queued entries, so the queue cannot overflow
    assign imem.req_valid = state == RUN && !redir &&
                            (int'(outstanding) + int'(count) - int'(pop)) < DEPTH;
    assign imem.req_addr  = pc;
    assign fire           = imem.req_valid && imem.req_ready;

    mips_fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({pc - 32'(int'(outstanding) * 4), imem.rsp_data}),
        .rdata (head),
        .count (count)
    );

    assign inst_valid  = count != '0;
    assign inst_data   = inst_valid ? head[31:0] : 32'h0;
    assign inst_pc     = inst_valid ? head[63:32] : 32'h0;
    assign inst_opcode = inst_data[31:26];
    assign inst_funct  = inst_data[5:0];
    assign fetch_err   = state == ERR;

    always_comb begin
        state_n = state;
        state_n = state == BOOT ? RUN :
                  (state == RUN && redirect_valid && redirect_pc[1:0] != 2'b00) ? ERR : state;
    end

    always_ff @(posedge clk)
        state <= rst ? BOOT : state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            pc          <= redir ? target : fire ? pc + 32'd4 : pc;
            outstanding <= outstanding + CW'(fire) - CW'(imem.rsp_valid);
            drop_cnt    <= redir ? outstanding - CW'(imem.rsp_valid) : drop_cnt - CW'(imem.rsp_valid && drop);
        end
    end

endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: scoreboard bench for mips_fetch with a variable-latency in-order memory model.
module tb_mips_fetch;
    logic        clk = 0, rst = 1, inst_ready = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        inst_valid, fetch_err;
    logic [31:0] inst_data, inst_pc;
    logic [5:0]  inst_opcode, inst_funct;

    mips_fetch_if imem();

    mips_fetch #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .inst_funct     (inst_funct),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, ncyc = 0, nfire = 0, deliv = 0, lat = 1;
    bit jflag = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    typedef struct {logic [31:0] a; int due;} t_rq;
    t_rq mq[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (jflag && a == 32'h0) ? 32'h0800_0040 : (32'h8C22_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // memory: accepts at the coming edge, answers lat cycles later, in order
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            mq.delete();
            imem.rsp_valid = 0;
        end else begin
            if (mq.size() > 0 && mq[0].due <= ncyc) begin
                imem.rsp_valid = 1;
                imem.rsp_data  = mem(mq[0].a);
                void'(mq.pop_front());
            end else imem.rsp_valid = 0;
            if (imem.req_valid && imem.req_ready) begin
                mq.push_back('{imem.req_addr, ncyc + lat});
                nfire++;
            end
        end
    end

    // consumes squashed by a same-cycle redirect are not deliveries
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            deliv++;
            chk("exp_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("pc", inst_pc, mon_e);
                chk("data", inst_data, mem(mon_e));
                chk("opcode", inst_opcode, mem(mon_e) >> 26);
                chk("funct", inst_funct, mem(mon_e) & 32'h3F);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int l, input bit j, input bit rdy);
        drive();
        rst = 1;
        lat = l;
        jflag = j;
        inst_ready = rdy;
        redirect_valid = 0;
        imem.req_ready = 1;
        exp_q.delete();
        drive();
        drive();
        rst = 0;
        deliv = 0;
        nfire = 0;
    endtask

    task automatic push_seq(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pc0 + 32'(i * 4));
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (deliv < n && k < budget) begin
            step();
            k++;
        end
        chk("deliv", deliv, n);
    endtask

    initial begin
        imem.req_ready = 1;
        imem.rsp_data  = 0;

        // streaming after reset
        start(1, 0, 1);
        push_seq(32'h0, 10);
        step();
        chk("rst_req_valid", imem.req_valid, 0);
        chk("rst_req_addr", imem.req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_opcode", inst_opcode, 0);
        chk("rst_funct", inst_funct, 0);
        chk("rst_fetch_err", fetch_err, 0);
        step();
        chk("t1_req0_v", imem.req_valid, 1);
        chk("t1_req0_a", imem.req_addr, 32'h0);
        step();
        chk("t1_req1_v", imem.req_valid, 1);
        chk("t1_req1_a", imem.req_addr, 32'h4);
        step();
        chk("t1_req2_a", imem.req_addr, 32'h8);
        chk("t1_iv", inst_valid, 1);
        chk("t1_pc0", inst_pc, 32'h0);
        step();
        chk("t1_pc1", inst_pc, 32'h4);
        step();
        chk("t1_pc2", inst_pc, 32'h8);
        run_until(8, 20);

        // decode stalled: only DEPTH requests, stable head
        start(1, 0, 0);
        repeat (8) step();
        chk("t2_fires", nfire, 2);
        chk("t2_req_valid", imem.req_valid, 0);
        chk("t2_iv", inst_valid, 1);
        chk("t2_pc", inst_pc, 32'h0);
        chk("t2_data", inst_data, mem(32'h0));
        repeat (4) step();
        chk("t2_data_hold", inst_data, mem(32'h0));
        chk("t2_fires_hold", nfire, 2);
        push_seq(32'h0, 4);
        drive();
        inst_ready = 1;
        run_until(4, 20);

        // redirect with two requests in flight
        start(3, 0, 0);
        for (int k = 0; k < 20 && nfire < 2; k++) step();
        chk("t3_fires", nfire, 2);
        drive();
        redirect_valid = 1;
        redirect_pc = 32'h100;
        inst_ready = 1;
        push_seq(32'h100, 4);
        step();
        chk("t3_outstanding", dut.outstanding, 2);
        chk("t3_no_req", imem.req_valid, 0);
        drive();
        redirect_valid = 0;
        step();
        chk("t3_drop_cnt", dut.drop_cnt, 2);
        run_until(4, 40);

        // misaligned redirect locks up until reset
        start(1, 0, 1);
        push_seq(32'h0, 12);
        run_until(4, 20);
        drive();
        redirect_valid = 1;
        redirect_pc = 32'h102;
        step();
        drive();
        redirect_valid = 0;
        step();
        chk("t4_err", fetch_err, 1);
        begin
            bit seen = 0;
            repeat (10) begin
                step();
                seen |= imem.req_valid | inst_valid;
            end
            chk("t4_quiet", seen, 0);
        end
        chk("t4_err_sticky", fetch_err, 1);
        start(1, 0, 1);
        push_seq(32'h0, 4);
        step();
        chk("t4_err_clr", fetch_err, 0);
        run_until(4, 20);

        // J at PC 0
        start(1, 1, 1);
`ifdef MIPS_FETCH_JMP_PREDECODE_EN
        exp_q.push_back(32'h0);
        push_seq(32'h100, 3);
`else
        push_seq(32'h0, 4);
`endif
        run_until(4, 20);

        // redirect colliding with a response and a pop
        start(1, 0, 1);
        push_seq(32'h0, 4);
        push_seq(32'h200, 4);
        run_until(4, 20);
        drive();
        redirect_valid = 1;
        redirect_pc = 32'h200;
        step();
        chk("t6_rsp", imem.rsp_valid, 1);
        chk("t6_pop", inst_valid, 1);
        chk("t6_out_before", dut.outstanding, 1);
        drive();
        redirect_valid = 0;
        step();
        chk("t6_empty", inst_valid, 0);
        chk("t6_drop_cnt", dut.drop_cnt, 0);
        chk("t6_outstanding", dut.outstanding, 0);
        run_until(8, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
